// File: rtl/hex_page_ctrl_pkg.sv
// Shared types and constants for the paged seven-segment controller:
// scheduler state encoding, segment patterns, channel value type and
// the 4-bit to active-low seven-segment decoder.
package hex_page_ctrl_pkg;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } sched_state_e;

    typedef logic [15:0] chan_val_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        // NOTE: the default assignment before the case keeps every path driven, so no latch can appear.
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_page_ctrl_if.sv
// Write bus between the requesters and the page controller. Each
// requester holds its request and data slice until it sees its ack.
interface hex_page_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    wr_req;
    logic [16*NUM_CH-1:0] wr_data;
    logic [NUM_CH-1:0]    wr_ack;

    modport master (output wr_req, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_data, output wr_ack);
endinterface

// File: rtl/hex_page_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, the first
// requesting channel wins, and the pointer moves just past the winner.
// The grant is combinational and suppressed while reset is high.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int PW     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_grant,
    output logic              o_valid,
    output logic [PW-1:0]     o_idx
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                // NOTE: blocking assignments here because later loop iterations must see the earlier found flag.
                w_cand = PW'((int'(r_ptr) + k) % NUM_CH);
                if (!o_valid && i_req[w_cand]) begin
                    o_valid         = 1'b1;
                    o_grant[w_cand] = 1'b1;
                    o_idx           = w_cand;
                end
            end
        end
    end

    // Advance the pointer past the granted channel; hold it when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= (o_idx == PW'(NUM_CH - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hex_page_ctrl.sv
// Paged seven-segment controller: requesters write 16-bit values into
// private channel registers through a round-robin arbiter; one channel
// at a time is shown on hex3..hex0, advancing on a dwell timer or on a
// next pulse. Optional feature macro HEX_PAGE_BLANK_EN inserts a blank
// gap of BLANK_CYCLES after every page advance.
module hex_page_ctrl
    import hex_page_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    hex_page_ctrl_if.slave            bus,
    input  logic                      hold,
    input  logic                      next,
    output logic [$clog2(NUM_CH)-1:0] page,
    output logic [6:0]                hex0,
    output logic [6:0]                hex1,
    output logic [6:0]                hex2,
    output logic [6:0]                hex3
);

    localparam int PW   = $clog2(NUM_CH);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    logic [NUM_CH-1:0] w_grant;
    logic              w_wr_valid;
    logic [PW-1:0]     w_wr_idx;
    chan_val_t         r_chan [NUM_CH];
    chan_val_t         w_shown;
    logic [PW-1:0]     r_page;
    logic [PW-1:0]     w_next_page;
    logic [CW-1:0]     r_cnt;
    logic              w_advance;
    logic [6:0]        r_hex [4];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (bus.wr_req),
        .o_grant (w_grant),
        .o_valid (w_wr_valid),
        .o_idx   (w_wr_idx)
    );

    assign bus.wr_ack = w_grant;

    // Capture the granted requester's data slice into its channel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the channel registers are a handful of flops, not a RAM, so resetting them is cheap and required.
            for (int i = 0; i < NUM_CH; i++) r_chan[i] <= '0;
        end else if (w_wr_valid) begin
            r_chan[w_wr_idx] <= bus.wr_data[16*int'(w_wr_idx) +: 16];
        end
    end

    assign w_shown     = r_chan[r_page];
    assign w_next_page = (r_page == PW'(NUM_CH - 1)) ? '0 : r_page + 1'b1;
    // next overrides hold; a next on the terminal count still advances once.
    assign w_advance   = next || (!hold && r_cnt == DWELL_LAST);

`ifdef HEX_PAGE_BLANK_EN
    localparam logic [0:0]    ST_SHOW    = SHOW;
    localparam logic [0:0]    ST_BLANK   = BLANK;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [0:0] r_state;

    // Page scheduler: dwell in SHOW, then sit out a blank gap on the new page.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SHOW;
            r_page  <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_BLANK) begin
            if (r_cnt == BLANK_LAST) begin
                r_state <= ST_SHOW;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_advance) begin
            r_state <= ST_BLANK;
            r_page  <= w_next_page;
            r_cnt   <= '0;
        end else if (!hold) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Register the decoded digits of the shown channel, or all-off while blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_hex[i] <= SEG_ZERO;
        end else begin
            for (int i = 0; i < 4; i++)
                r_hex[i] <= (r_state == ST_BLANK) ? SEG_BLANK : seg7_decode(w_shown[4*i +: 4]);
        end
    end
`else
    // Page scheduler: dwell counter with hold freeze, advancing straight to the next page.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_page <= '0;
            r_cnt  <= '0;
        end else if (w_advance) begin
            r_page <= w_next_page;
            r_cnt  <= '0;
        end else if (!hold) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Register the decoded digits of the shown channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_hex[i] <= SEG_ZERO;
        end else begin
            for (int i = 0; i < 4; i++) r_hex[i] <= seg7_decode(w_shown[4*i +: 4]);
        end
    end
`endif

    assign page = r_page;
    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];

endmodule

// File: tb/tb_hex_page_ctrl.sv
// Bench for hex_page_ctrl (NUM_CH=4, DWELL_CYCLES=8, BLANK_CYCLES=2).
// A cycle-level behavioural model tracks the channel values, page and
// display contents; a compare process checks the DUT against it every
// cycle, and directed sequences pin key values with literal expectations.
module tb_hex_page_ctrl;

    localparam int NUM_CH = 4;
    localparam int DWELL  = 8;
    localparam int BLANKC = 2;
    localparam logic [6:0] ZERO = 7'b1000000;
    localparam logic [6:0] OFF  = 7'h7F;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       next;
    logic [1:0] page;
    logic [6:0] hex0, hex1, hex2, hex3;

    hex_page_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    hex_page_ctrl #(
        .NUM_CH       (NUM_CH),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANKC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .hold  (hold),
        .next  (next),
        .page  (page),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Active-low gfedcba digit patterns 0..F.
    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // ---------------- behavioural model ----------------
    logic [15:0] m_chan [NUM_CH];
    int          m_page, m_rr, m_ticks, m_g;
    bit          m_blank, m_valid = 1'b0;
    logic [15:0] m_disp_val;
    bit          m_disp_blank;

    function automatic int m_grant();
        if (reset) return -1;
        for (int k = 0; k < NUM_CH; k++)
            if (bus.wr_req[(m_rr + k) % NUM_CH]) return (m_rr + k) % NUM_CH;
        return -1;
    endfunction

    function automatic logic [3:0] m_ack();
        int g;
        g = m_grant();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    function automatic logic [6:0] m_hex(input int d);
        return m_disp_blank ? OFF : seg_tab[m_disp_val[4*d +: 4]];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) m_chan[i] = 16'h0;
            m_page = 0; m_rr = 0; m_ticks = 0; m_blank = 0;
            m_disp_val = 16'h0; m_disp_blank = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_g = m_grant();
            // Display registers capture what was visible before this edge.
            m_disp_val   = m_chan[m_page];
            m_disp_blank = m_blank;
            if (m_g >= 0) begin
                m_chan[m_g] = bus.wr_data[16*m_g +: 16];
                m_rr = (m_g + 1) % NUM_CH;
            end
            if (m_blank) begin
                m_ticks++;
                if (m_ticks == BLANKC) begin
                    m_blank = 0;
                    m_ticks = 0;
                end
            end else if (next || (!hold && m_ticks == DWELL - 1)) begin
                m_page  = (m_page + 1) % NUM_CH;
                m_ticks = 0;
`ifdef HEX_PAGE_BLANK_EN
                m_blank = 1;
`endif
            end else if (!hold) begin
                m_ticks++;
            end
        end
    end

    // Compare process: inputs never change at negedge, outputs are settled.
    always @(negedge clk) begin
        if (m_valid) begin
            check("page", 32'(page), 32'(m_page));
            check("wr_ack", 32'(bus.wr_ack), 32'(m_ack()));
            check("hex0", 32'(hex0), 32'(m_hex(0)));
            check("hex1", 32'(hex1), 32'(m_hex(1)));
            check("hex2", 32'(hex2), 32'(m_hex(2)));
            check("hex3", 32'(hex3), 32'(m_hex(3)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; next = 1'b0;
        bus.wr_req = '0; bus.wr_data = '0;
        tick(3);
        reset = 1'b0;

        // Reset state.
        check("rst_hex0", 32'(hex0), 32'(ZERO));
        check("rst_hex1", 32'(hex1), 32'(ZERO));
        check("rst_hex2", 32'(hex2), 32'(ZERO));
        check("rst_hex3", 32'(hex3), 32'(ZERO));
        check("rst_page", 32'(page), 32'd0);
        check("rst_ack", 32'(bus.wr_ack), 32'd0);

`ifndef HEX_PAGE_BLANK_EN
        // Load ch1 = 1234, watch dwell-driven paging and wrap.
        bus.wr_req = 4'b0010;
        bus.wr_data[31:16] = 16'h1234;
        #1 check("ack_ch1", 32'(bus.wr_ack), 32'b0010);
        tick(1);
        bus.wr_req = 4'b0000;
        tick(6);
        check("dwell_p0_last", 32'(page), 32'd0);
        tick(1);
        check("dwell_p1", 32'(page), 32'd1);
        tick(1);
        check("p1_hex3", 32'(hex3), 32'(7'b1111001));
        check("p1_hex2", 32'(hex2), 32'(7'b0100100));
        check("p1_hex1", 32'(hex1), 32'(7'b0110000));
        check("p1_hex0", 32'(hex0), 32'(7'b0011001));
        tick(22);
        check("p3_before_wrap", 32'(page), 32'd3);
        tick(1);
        check("wrap_p0", 32'(page), 32'd0);
`endif

        // Round-robin: all four requesting, pointer at 0 after reset.
        do_reset();
        bus.wr_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.wr_req  = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) begin
            #1 check("ack_order", 32'(bus.wr_ack), 32'(1 << i));
            tick(1);
            bus.wr_req[i] = 1'b0;
        end
        check("arb_ch0_hex0", 32'(hex0), 32'(7'b1111001));
        check("arb_ch0_hex3", 32'(hex3), 32'(7'b1111001));

`ifndef HEX_PAGE_BLANK_EN
        // Hold on page 2, next during hold, next on terminal count.
        do_reset();
        next = 1'b1;
        tick(2);
        next = 1'b0;
        hold = 1'b1;
        tick(20);
        check("hold_p2", 32'(page), 32'd2);
        next = 1'b1;
        tick(1);
        check("next_in_hold", 32'(page), 32'd3);
        next = 1'b0;
        hold = 1'b0;
        tick(7);
        next = 1'b1;
        tick(1);
        check("next_at_tc", 32'(page), 32'd0);
        next = 1'b0;
        tick(7);
        check("restart_p0", 32'(page), 32'd0);
        tick(1);
        check("restart_p1", 32'(page), 32'd1);
`else
        // Blank gap after an advance; next ignored; reset during blank.
        do_reset();
        next = 1'b1;
        tick(1);
        check("blank_page", 32'(page), 32'd1);
        tick(1);
        check("blank_hex_a", 32'(hex0), 32'(OFF));
        check("blank_hex3_a", 32'(hex3), 32'(OFF));
        tick(1);
        next = 1'b0;
        check("blank_hex_b", 32'(hex0), 32'(OFF));
        check("blank_next_ign", 32'(page), 32'd1);
        tick(1);
        check("after_blank", 32'(hex0), 32'(ZERO));
        check("after_blank_pg", 32'(page), 32'd1);
        next = 1'b1;
        tick(1);
        next = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_blank_page", 32'(page), 32'd0);
        check("rst_blank_hex", 32'(hex0), 32'(ZERO));
`endif

        // Reset during a pending write: ack suppressed, state cleared.
        bus.wr_req = 4'b0100;
        bus.wr_data[47:32] = 16'hBEEF;
        reset = 1'b1;
        #1 check("rst_ack_mask", 32'(bus.wr_ack), 32'd0);
        tick(1);
        bus.wr_req = 4'b0000;
        reset = 1'b0;
        check("rst_wr_page", 32'(page), 32'd0);
        check("rst_wr_hex2", 32'(hex2), 32'(ZERO));
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_page_ctrl.md
# hex_page_ctrl

Time-multiplexed controller for the four-digit seven-segment bank. Up to NUM_CH requesters (game state, debug probes, score logic) each post a 16-bit value through a round-robin write arbiter into a private channel register; a page scheduler shows one channel at a time on HEX3..HEX0, advancing on a dwell timer or on a manual `next` pulse. Each digit is decoded by the codebase's existing 4-bit to active-low seven-segment decoder.

## Interface
- NUM_CH, 4, number of requester channels (2..8)
- DWELL_CYCLES, 50_000_000, clock cycles each page is shown (1 s at 50 MHz)
- BLANK_CYCLES, 5_000_000, blank gap between pages (used only with HEX_PAGE_BLANK_EN)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_req  in  NUM_CH  per-channel write request, held until acked
- wr_data  in  16*NUM_CH  channel i value at bits [16i+15:16i]
- wr_ack  out  NUM_CH  one-hot grant, combinational, at most one bit high
- hold  in  1  level; freezes the dwell timer
- next  in  1  single-cycle pulse; advance page immediately
- page  out  $clog2(NUM_CH)  channel currently selected
- hex0..hex3  out  7 each  active-low segments; hex0 = value[3:0], hex3 = value[15:12]

## Operation
- Write arbiter: round-robin over wr_req; priority starts at rr_ptr, reset 0. Granted channel i gets wr_ack[i]=1 that cycle; chan_reg[i] <= its wr_data slice at that edge; rr_ptr <= (i+1) mod NUM_CH. No request: no ack, rr_ptr unchanged.
- Requester protocol: hold wr_req and wr_data stable until wr_ack seen; a request held after its ack is a new write.
- Scheduler states: SHOW, BLANK (BLANK exists only with HEX_PAGE_BLANK_EN).
- SHOW: dwell counter counts 0..DWELL_CYCLES-1 while hold=0; hold=1 freezes it. Terminal count or next=1 triggers advance: page <= (page+1) mod NUM_CH, counter <= 0.
- next has priority over hold; next coincident with terminal count advances exactly once.
- BLANK: counter counts 0..BLANK_CYCLES-1, ignores hold and next, then returns to SHOW with counter 0.
- Output: hex regs load the decode of chan_reg[page] in SHOW, 7'h7F in BLANK.
- Reset: chan_reg all 0, page 0, rr_ptr 0, counter 0, state SHOW, hex0..hex3 = 7'b1000000 (digit "0"), wr_ack 0.

## Timing
- wr_ack is combinational from wr_req and rr_ptr in the same cycle.
- Write to the displayed channel: chan_reg updates at edge E, hex outputs reflect it at E+1.
- Page change: page updates at edge E, hex outputs show the new page at E+1 (one-cycle registered latency).
- Write and page advance at the same edge both take effect; hex at E+1 shows the written value if it targets the new page.
- Reset asserted mid-write or mid-BLANK: all state returns to reset values at the next edge; any ack in that cycle is discarded.
- Page wraps NUM_CH-1 -> 0; counters never exceed their terminal values.

## Configuration
- HEX_PAGE_BLANK_EN defined: each advance enters BLANK for BLANK_CYCLES with all segments off, page already updated; next ignored during BLANK.
- Undefined: BLANK state, its counter compare and BLANK_CYCLES logic are not built; advance goes directly SHOW -> SHOW with new page.

## Structure
- Shared package: state enum (SHOW, BLANK), SEG_BLANK = 7'h7F, SEG_ZERO = 7'b1000000, 16-bit channel value typedef.
- Sub-module `rr_arbiter` (NUM_CH req in, one-hot grant out, pointer update on grant) is natural; four decoder instances handle digits.

## Test plan
- Reset, no activity -> hex3..hex0 = 7'b1000000 each, page 0, wr_ack 0.
- NUM_CH=4, DWELL_CYCLES=8: load ch1=16'h1234 -> page 0 for 8 cycles, page 1 after, hex3..hex0 show 1,2,3,4 one cycle later; page wraps 3 -> 0 after 32 cycles.
- wr_req=4'b1111 held with distinct data -> acks in order ch0, ch1, ch2, ch3, one per cycle; all four registers correct.
- hold=1 for 20 cycles on page 2 -> page stays 2; next pulse during hold -> page 3 next edge, counter restarts.
- next coincident with terminal count -> page advances by exactly 1.
- HEX_PAGE_BLANK_EN, BLANK_CYCLES=2: advance -> 2 cycles of all hex = 7'h7F, next ignored there; reset asserted during BLANK -> SHOW, page 0, zeros next edge.
